uart_tx_queue: RTL

Upstream feeder for the UART transmitter: a small byte queue that captures switch data on a load pulse and, on a send pulse, drains every queued byte through the transmitter one frame at a time. Bytes leave in the order they were loaded. The block drives the transmitter's `tx_start`/`data_in` pair and consumes its `tx_done` pulse. It sits between the debounced-button / switch logic and `uart_transmitter`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/tx_queue_mem.sv | 79 +++++++
 rtl/uart_tx_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: default widths and the transmit
//               queue state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DBITS    = 8;
   localparam int UART_FIFO_EXP = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } tx_queue_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/tx_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : tx_queue_mem
// Description : Circular byte store with wrapping read/write pointers and a
//               separately held occupancy count. Push/pop are pre-qualified
//               by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_queue_mem
   import uart_pkg::*;
#(
   parameter int DBITS     = UART_DBITS,
   parameter int DEPTH_EXP = UART_FIFO_EXP
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DBITS-1:0]     write_data,
   output logic [DBITS-1:0]     read_data,
   output logic [DEPTH_EXP:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int                 c_DEPTH     = 1 << DEPTH_EXP;
   localparam logic [DEPTH_EXP:0] c_DEPTH_CNT = c_DEPTH[DEPTH_EXP:0];

   logic [DBITS-1:0]     r_mem [c_DEPTH];
   logic [DEPTH_EXP-1:0] r_wr_ptr;
   logic [DEPTH_EXP-1:0] r_rd_ptr;
   logic [DEPTH_EXP:0]   r_count;

   // Storage: cleared on reset, written at the tail on push
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (push) begin
         r_mem[r_wr_ptr] <= write_data;
      end
   end

   // Pointers advance independently and wrap naturally at the depth
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign read_data = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign full      = (r_count == c_DEPTH_CNT);
   assign empty     = (r_count == '0);

endmodule : tx_queue_mem
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue feeding the UART transmitter. Loads push switch
//               data; a send pulse drains every queued byte, one frame per
//               tx_start/tx_done handshake, oldest first.
//               Build option: UART_TX_QUEUE_AUTOSEND_EN - when defined the
//               queue drains whenever it holds data and send_all is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DBITS     = UART_DBITS,
   parameter int DEPTH_EXP = UART_FIFO_EXP
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 send_all,
   input  logic [DBITS-1:0]     write_data,
   input  logic                 tx_done,
   output logic                 tx_start,
   output logic [DBITS-1:0]     tx_data,
   output logic [DEPTH_EXP:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 busy
);

   localparam logic [1:0] c_S_IDLE  = 2'(IDLE);
   localparam logic [1:0] c_S_START = 2'(START);
   localparam logic [1:0] c_S_WAIT  = 2'(WAIT);

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   logic       w_push;
   logic       w_pop;
   logic       w_go;
   logic       w_more_after_pop;

   // A full queue rejects loads even when the head leaves this same cycle
   assign w_push = load & ~full;
   // Only the completion of a frame we started retires the head byte
   assign w_pop  = (r_state == c_S_WAIT) & tx_done;

`ifdef UART_TX_QUEUE_AUTOSEND_EN
   assign w_go = 1'b1;
`else
   assign w_go = send_all;
`endif

   // Bytes remain after this pop if more than one was queued or one arrives now
   assign w_more_after_pop = (count > {{DEPTH_EXP{1'b0}}, 1'b1}) | w_push;

   tx_queue_mem #(
      .DBITS     (DBITS),
      .DEPTH_EXP (DEPTH_EXP)
   ) u_mem (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .push       (w_push),
      .pop        (w_pop),
      .write_data (write_data),
      .read_data  (tx_data),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   // Next-state decode for the drain sequencer
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_go && !empty) begin
               w_state_next = c_S_START;
            end
         end
         c_S_START: begin
            w_state_next = c_S_WAIT;
         end
         c_S_WAIT: begin
            if (tx_done) begin
               w_state_next = w_more_after_pop ? c_S_START : c_S_IDLE;
            end
         end
         default: begin
            w_state_next = c_S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any frame in flight
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign tx_start = (r_state == c_S_START);
   assign busy     = (r_state != c_S_IDLE);

endmodule : uart_tx_queue
`default_nettype wire
